uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing one UART transmitter (8N1, baud-tick driven) among
//  NUM_REQ byte producers. Picks one requester, hands its byte to the transmitter

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit subsystem: frame geometry and the
// arbiter state encoding.
package uart_pkg;

  // One data byte per frame; 8N1 framing adds one start and one stop bit.
  localparam int BYTE_W  = 8;
  localparam int FRAME_W = BYTE_W + 2;

  // Arbiter state encoding, fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// scanning last+1, last+2, ... (mod NUM_REQ), plus a flag that any request is up.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest candidate so the nearest valid one wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    winner    = '0;
    cand      = '0;
    any_valid = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (req[cand]) winner = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte
// producers, with a watchdog that aborts a frame whose tx_done never arrives.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = BYTE_W,
  parameter int TIMEOUT = 4095
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] last, last_n;
  logic [IDX_W-1:0] grant_n;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic [DATA_W-1:0] data_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic [NUM_REQ-1:0] ready_n;
  logic             start_n, terr_n, busy_n;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req_valid),
    .last      (last),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Watchdog increments but sticks at all-ones instead of wrapping.
  assign count_inc = (&count) ? count : count + CNT_W'(1);

  // Next-state and next-output decision; all outputs are registered below.
  always_comb begin
    state_n = state;
    last_n  = last;
    grant_n = grant_id;
    data_n  = tx_data;
    count_n = count;
    ready_n = '0;
    start_n = 1'b0;
    terr_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_valid && !tx_busy) begin
          state_n = ST_ISSUE;
          grant_n = winner;
          data_n  = req_data[int'(winner)*DATA_W +: DATA_W];
          ready_n = NUM_REQ'(1) << winner;
          start_n = 1'b1;
          // Cleared on entry to ISSUE so the ISSUE cycle is itself counted and
          // the abort lands exactly TIMEOUT cycles after the start pulse.
          count_n = '0;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
        count_n = count_inc;
      end
      ST_WAIT: begin
        // tx_done is tested first so a completion on the abort cycle wins.
        if (tx_done) begin
          state_n = ST_IDLE;
          last_n  = grant_id;
        end else if (count == CNT_W'(TIMEOUT - 1)) begin
          state_n = ST_IDLE;
          last_n  = grant_id;
          terr_n  = 1'b1;
        end else begin
          count_n = count_inc;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      last        <= IDX_W'(NUM_REQ - 1);
      grant_id    <= '0;
      tx_data     <= '0;
      count       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      grant_id    <= grant_n;
      tx_data     <= data_n;
      count       <= count_n;
      req_ready   <= ready_n;
      tx_start    <= start_n;
      timeout_err <= terr_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of arbitration vectors plus
// hand-written sequences for busy gating, watchdog and mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_busy;
  logic                      tx_done;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic [1:0]        grant;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0]        valid;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [1:0]                exp_grant;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive a request pattern, expect an ISSUE after exp_lat cycles, then compare
  // the handed-off grant against the scoreboard entry. Valids drop afterwards.
  task automatic send(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*DATA_W-1:0] data,
                      input logic [1:0] exp_g, input int exp_lat);
    exp_t e;
    int   n;
    e.grant = exp_g;
    e.data  = data[int'(exp_g)*DATA_W +: DATA_W];
    sb.push_back(e);
    req_valid = valid;
    req_data  = data;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tx_start && n < 20);
    check("issue_latency", n, exp_lat);
    if (tx_start) begin
      e = sb.pop_front();
      check("grant_id", {30'd0, grant_id}, {30'd0, e.grant});
      check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
      check("req_ready", {28'd0, req_ready}, 32'(4'b0001 << e.grant));
      check("busy_in_issue", {31'd0, busy}, 32'd1);
    end
    req_valid = '0;
  endtask

  // Sit in WAIT for n cycles, then complete the frame with a tx_done pulse.
  task automatic finish_frame(input int n, input logic [DATA_W-1:0] exp_data);
    repeat (n) cyc();
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    check("tx_data_held", {24'd0, tx_data}, {24'd0, exp_data});
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("no_timeout_on_done", {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // Hard time limit so a hung DUT still ends the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NUM_REQ*DATA_W-1:0] d;
    int n;

    // Arbitration table: grants follow the round-robin pointer row to row.
    vecs[0].valid = 4'b1111; vecs[0].exp_grant = 2'd0;
    vecs[1].valid = 4'b1111; vecs[1].exp_grant = 2'd1;
    vecs[2].valid = 4'b1111; vecs[2].exp_grant = 2'd2;
    vecs[3].valid = 4'b1111; vecs[3].exp_grant = 2'd3;
    vecs[4].valid = 4'b1111; vecs[4].exp_grant = 2'd0;
    vecs[5].valid = 4'b1010; vecs[5].exp_grant = 2'd1;
    vecs[6].valid = 4'b1010; vecs[6].exp_grant = 2'd3;
    vecs[7].valid = 4'b0001; vecs[7].exp_grant = 2'd0;
    vecs[8].valid = 4'b0110; vecs[8].exp_grant = 2'd1;
    vecs[9].valid = 4'b1000; vecs[9].exp_grant = 2'd3;
    for (int r = 0; r < 10; r++)
      for (int i = 0; i < NUM_REQ; i++)
        vecs[r].data[i*DATA_W +: DATA_W] = 8'((r << 4) | i | 8'h80);

    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1 check_all_zero("reset");
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check_all_zero("post_reset_idle");

    // Rotation and pattern table; each frame completes with tx_done.
    for (int r = 0; r < 10; r++) begin
      send(vecs[r].valid, vecs[r].data, vecs[r].exp_grant, 1);
      finish_frame(3, vecs[r].data[int'(vecs[r].exp_grant)*DATA_W +: DATA_W]);
    end

    // Single requester 2 with 0xA5, tx_done ten cycles after ISSUE.
    d = 32'h1234_0000 | 32'h00A5_0000;
    d[2*DATA_W +: DATA_W] = 8'hA5;
    send(4'b0100, d, 2'd2, 1);
    finish_frame(9, 8'hA5);
    check("grant_id_held_idle", {30'd0, grant_id}, 32'd2);

    // Transmitter busy holds the arbiter in IDLE.
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("gate_no_start", {31'd0, tx_start}, 32'd0);
      check("gate_idle", {31'd0, busy}, 32'd0);
    end
    tx_busy = 1'b0;
    send(4'b0001, 32'h0000_003C, 2'd0, 1);
    finish_frame(2, 8'h3C);

    // Watchdog abort: no tx_done, error pulse TIMEOUT cycles after the start.
    send(4'b1111, 32'h4433_2211, 2'd1, 1);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!timeout_err && n < 40);
    check("timeout_delay", n, TIMEOUT);
    check("busy_at_timeout", {31'd0, busy}, 32'd0);
    cyc();
    check("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);

    // Next grant moves past the aborted requester; done on the abort cycle wins.
    send(4'b1111, 32'h4433_2211, 2'd2, 1);
    repeat (TIMEOUT - 1) cyc();
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    check("done_wins_no_err", {31'd0, timeout_err}, 32'd0);
    check("done_wins_idle", {31'd0, busy}, 32'd0);
    cyc();
    check("done_wins_no_late_err", {31'd0, timeout_err}, 32'd0);

    // Reset in the middle of WAIT clears everything without waiting for a clock.
    send(4'b1111, 32'h4433_2211, 2'd3, 1);
    repeat (3) cyc();
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_reset_no_err", {31'd0, timeout_err}, 32'd0);
    send(4'b1001, 32'h9900_00AA, 2'd0, 1);
    finish_frame(2, 8'hAA);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
